cluster_power_seq: RTL and testbench
====================================

// Module: cluster_power_seq
// PURPOSE
//  Sequences cluster power-up, boot and power-down for the SoC domain.
//  Drives cluster power, bypass, clock-enable, reset, fetch-enable and boot address.
//  Accepts ops over a valid/ready command port and waits on cluster_busy before shutdown.
//  Sits in the SoC domain between the control registers and the cluster interface.
// PARAMETERS
//  PWR_UP_CYCLES     16    cycles spent in PWR_UP (power settle), >=1
//  CLK_SETTLE_CYCLES 4     cycles spent in CLK_ON / CLK_OFF, >=1
//  RST_HOLD_CYCLES   8     cycles spent in RST_REL / RST_ASSERT, >=1
//  DRAIN_TIMEOUT     1024  maximum cycles in DRAIN, >=1
//  BOOT_ADDR_WIDTH   64    width of the boot address
// PORTS
//  clk_i                   in   1    SoC clock
//  rst_ni                  in   1    reset, asynchronous, active-low
//  test_mode_i             in   1    DFT: when 1, cluster_rstn_o = rst_ni (combinational)
//  cmd_valid_i             in   1    command valid
//  cmd_ready_o             out  1    command ready
//  cmd_op_i                in   2    0 NOP, 1 POWER_ON, 2 START, 3 POWER_OFF
//  cmd_boot_addr_i         in   BAW  boot address, sampled with START
//  cluster_busy_i          in   1    cluster busy
//  cluster_pow_o           out  1    cluster power request
//  cluster_byp_o           out  1    cluster bypass/isolation
//  cluster_clk_en_o        out  1    cluster clock gate enable
//  cluster_rstn_o          out  1    cluster reset, active-low
//  cluster_fetch_enable_o  out  1    core fetch enable
//  cluster_boot_addr_o     out  BAW  latched boot address
//  state_o                 out  4    current FSM state encoding
//  done_evt_o              out  1    1-cycle pulse on entering READY or OFF
//  err_evt_o               out  1    1-cycle pulse after an illegal command is accepted
//  timeout_evt_o           out  1    1-cycle pulse when the DRAIN timeout expires
// BEHAVIOUR
//  Reset values: pow=0, byp=1, clk_en=0, rstn=0, fetch=0, boot_addr=0, state=OFF, all evts=0.
//  Async reset at any point (including mid-sequence) forces these values immediately.
//  All outputs are registered, except cmd_ready_o (decoded from state) and the test_mode rstn mux.
//  cmd_ready_o=1 only in OFF, READY and RUNNING; a handshake is valid&ready on a rising edge.
//  FSM dwell: a timed state of N cycles is left exactly N cycles after entry.
//  Output changes occur on the same edge as the state transition.
//  Up sequence:
//   OFF --POWER_ON--> PWR_UP (pow=1) --PWR_UP_CYCLES--> CLK_ON (clk_en=1, byp=0)
//   --CLK_SETTLE--> RST_REL (rstn=1) --RST_HOLD--> READY.
//  With default parameters, relative to the POWER_ON edge t:
//   pow at t, clk_en at t+16, rstn at t+20, READY at t+28.
//  READY --START--> RUNNING: boot_addr latched and fetch=1 on the same edge.
//  READY|RUNNING --POWER_OFF--> DRAIN: fetch=0 on entry.
//  DRAIN exits on the first sampled cluster_busy_i=0, or after DRAIN_TIMEOUT cycles.
//   On timeout: timeout_evt pulse, then proceed to RST_ASSERT.
//  Down sequence: RST_ASSERT (rstn=0) --RST_HOLD--> CLK_OFF (clk_en=0, byp=1)
//   --CLK_SETTLE--> OFF (pow=0).
//  cluster_byp_o = !cluster_clk_en_o at all times.
//  Illegal commands are accepted, leave state and outputs unchanged, and pulse err_evt next cycle:
//   START or POWER_OFF in OFF; POWER_ON in READY or RUNNING; START in RUNNING.
//  NOP is accepted with no effect and no error.
//  boot_addr holds its value until the next legal START.
// STRUCTURE
//  cluster_seq_pkg holds: state_e enum (OFF, PWR_UP, CLK_ON, RST_REL, READY, RUNNING,
//   DRAIN, RST_ASSERT, CLK_OFF), op_e enum, and the counter width derived from max(params).
//  One sub-module, cluster_seq_dwell_cnt: loadable down-counter with load value and zero flag,
//   shared by all timed states and by DRAIN.
// TESTING
//  1 Reset, POWER_ON at edge 0 -> pow=1@0, clk_en=1@16, rstn=1@20, READY+done_evt@28,
//    cmd_ready low throughout 1..27.
//  2 READY, START addr 0x1C008080 -> fetch=1, boot_addr=0x1C008080 next cycle, state RUNNING.
//  3 RUNNING, POWER_OFF, busy=1 for 50 cycles -> fetch=0 immediately, rstn stays 1 until busy=0;
//    then rstn=0, clk_en=0 8 cycles later, pow=0 plus done_evt 4 cycles after that.
//  4 DRAIN_TIMEOUT=32, busy stuck at 1 -> timeout_evt after 32 cycles in DRAIN, sequence completes to OFF.
//  5 START in OFF -> err_evt pulse, outputs unchanged.
//    cmd_valid held during PWR_UP -> not accepted until READY.
//  6 rst_ni low at PWR_UP cycle 5 -> all outputs at reset values asynchronously;
//    test_mode_i=1 -> cluster_rstn_o tracks rst_ni.

Source files
------------

// File: rtl/cluster_seq_pkg.sv
// Shared types and helpers for the cluster power sequencer.
//   state_e   : FSM state encoding (also exported on state_o)
//   op_e      : command opcodes carried on cmd_op_i
//   cnt_width : dwell-counter width needed to hold the largest (N-1) load value
package cluster_seq_pkg;

    typedef enum logic [3:0] {
        OFF        = 4'd0,
        PWR_UP     = 4'd1,
        CLK_ON     = 4'd2,
        RST_REL    = 4'd3,
        READY      = 4'd4,
        RUNNING    = 4'd5,
        DRAIN      = 4'd6,
        RST_ASSERT = 4'd7,
        CLK_OFF    = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP       = 2'd0,
        OP_POWER_ON  = 2'd1,
        OP_START     = 2'd2,
        OP_POWER_OFF = 2'd3
    } op_e;

    localparam int unsigned DEF_PWR_UP_CYCLES     = 16;
    localparam int unsigned DEF_CLK_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_RST_HOLD_CYCLES   = 8;
    localparam int unsigned DEF_DRAIN_TIMEOUT     = 1024;

    // The counter is loaded with N-1, so clog2(max N) bits suffice (at least 1).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cluster_seq_dwell_cnt.sv
// Loadable down-counter used for every timed state and for the DRAIN timeout.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load load_val_i this cycle (takes priority over counting)
//   load_val_i    : value to load (dwell length minus one)
//   zero_o        : counter currently holds zero
// The counter saturates at zero when not reloaded.
module cluster_seq_dwell_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_power_seq.sv
// Cluster power-up / boot / power-down sequencer for the SoC domain.
//   clk_i, rst_ni            : SoC clock, async active-low reset
//   test_mode_i              : DFT override, cluster_rstn_o follows rst_ni directly
//   cmd_valid_i/cmd_ready_o  : command handshake, a command is taken on a rising edge
//                              where valid and ready are both high; ready depends only
//                              on state and valid may be held across not-ready cycles
//   cmd_op_i                 : NOP / POWER_ON / START / POWER_OFF
//   cmd_boot_addr_i          : boot address, captured by a legal START
//   cluster_busy_i           : cluster still active, drained before shutdown
//   cluster_*_o              : power, bypass, clock enable, reset, fetch enable, boot addr
//   state_o                  : current FSM state
//   done_evt_o/err_evt_o/timeout_evt_o : single-cycle event pulses
module cluster_power_seq
    import cluster_seq_pkg::*;
#(
    parameter int unsigned PWR_UP_CYCLES     = DEF_PWR_UP_CYCLES,
    parameter int unsigned CLK_SETTLE_CYCLES = DEF_CLK_SETTLE_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES   = DEF_RST_HOLD_CYCLES,
    parameter int unsigned DRAIN_TIMEOUT     = DEF_DRAIN_TIMEOUT,
    parameter int unsigned BOOT_ADDR_WIDTH   = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       test_mode_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_op_i,
    input  logic [BOOT_ADDR_WIDTH-1:0] cmd_boot_addr_i,
    input  logic                       cluster_busy_i,
    output logic                       cluster_pow_o,
    output logic                       cluster_byp_o,
    output logic                       cluster_clk_en_o,
    output logic                       cluster_rstn_o,
    output logic                       cluster_fetch_enable_o,
    output logic [BOOT_ADDR_WIDTH-1:0] cluster_boot_addr_o,
    output logic [3:0]                 state_o,
    output logic                       done_evt_o,
    output logic                       err_evt_o,
    output logic                       timeout_evt_o
);

    localparam int unsigned CNT_W = cnt_width(PWR_UP_CYCLES, CLK_SETTLE_CYCLES,
                                              RST_HOLD_CYCLES, DRAIN_TIMEOUT);
    // A state of N cycles is left N edges after entry: load N-1, exit when zero.
    localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(PWR_UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CLK   = CNT_W'(CLK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DRAIN = CNT_W'(DRAIN_TIMEOUT - 1);

    state_e                     state_q, state_d;
    logic                       pow_q, pow_d;
    logic                       byp_q, byp_d;
    logic                       clk_en_q, clk_en_d;
    logic                       rstn_q, rstn_d;
    logic                       fetch_q, fetch_d;
    logic [BOOT_ADDR_WIDTH-1:0] boot_q, boot_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       to_q, to_d;

    logic                       cnt_load;
    logic [CNT_W-1:0]           cnt_load_val;
    logic                       cnt_zero;
    logic                       cmd_ready;
    logic                       cmd_fire;
    op_e                        op;

    assign cmd_ready = (state_q == OFF) || (state_q == READY) || (state_q == RUNNING);
    assign cmd_fire  = cmd_valid_i && cmd_ready;
    assign op        = op_e'(cmd_op_i);

    cluster_seq_dwell_cnt #(
        .WIDTH (CNT_W)
    ) u_dwell_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        pow_d        = pow_q;
        clk_en_d     = clk_en_q;
        rstn_d       = rstn_q;
        fetch_d      = fetch_q;
        boot_d       = boot_q;
        err_d        = 1'b0;
        to_d         = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            OFF: begin
                if (cmd_fire) begin
                    if (op == OP_POWER_ON) begin
                        state_d      = PWR_UP;
                        pow_d        = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = LD_PWR;
                    end else if (op != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            PWR_UP: begin
                if (cnt_zero) begin
                    state_d      = CLK_ON;
                    clk_en_d     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_CLK;
                end
            end
            CLK_ON: begin
                if (cnt_zero) begin
                    state_d      = RST_REL;
                    rstn_d       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_RST;
                end
            end
            RST_REL: begin
                if (cnt_zero) state_d = READY;
            end
            READY, RUNNING: begin
                if (cmd_fire) begin
                    if (op == OP_POWER_OFF) begin
                        state_d      = DRAIN;
                        fetch_d      = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = LD_DRAIN;
                    end else if (op == OP_START && state_q == READY) begin
                        state_d = RUNNING;
                        fetch_d = 1'b1;
                        boot_d  = cmd_boot_addr_i;
                    end else if (op != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Idle cluster wins over a coincident timeout: no timeout event then.
                if (!cluster_busy_i || cnt_zero) begin
                    state_d      = RST_ASSERT;
                    rstn_d       = 1'b0;
                    to_d         = cluster_busy_i;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_RST;
                end
            end
            RST_ASSERT: begin
                if (cnt_zero) begin
                    state_d      = CLK_OFF;
                    clk_en_d     = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_CLK;
                end
            end
            CLK_OFF: begin
                if (cnt_zero) begin
                    state_d = OFF;
                    pow_d   = 1'b0;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        byp_d  = !clk_en_d;
        done_d = (state_d != state_q) && ((state_d == READY) || (state_d == OFF));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= OFF;
            pow_q    <= 1'b0;
            byp_q    <= 1'b1;
            clk_en_q <= 1'b0;
            rstn_q   <= 1'b0;
            fetch_q  <= 1'b0;
            boot_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pow_q    <= pow_d;
            byp_q    <= byp_d;
            clk_en_q <= clk_en_d;
            rstn_q   <= rstn_d;
            fetch_q  <= fetch_d;
            boot_q   <= boot_d;
            done_q   <= done_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign cmd_ready_o            = cmd_ready;
    assign cluster_pow_o          = pow_q;
    assign cluster_byp_o          = byp_q;
    assign cluster_clk_en_o       = clk_en_q;
    assign cluster_rstn_o         = test_mode_i ? rst_ni : rstn_q;
    assign cluster_fetch_enable_o = fetch_q;
    assign cluster_boot_addr_o    = boot_q;
    assign state_o                = state_q;
    assign done_evt_o             = done_q;
    assign err_evt_o              = err_q;
    assign timeout_evt_o          = to_q;

endmodule

// File: tb/tb_cluster_power_seq.sv
module tb_cluster_power_seq;
  import cluster_seq_pkg::*;

  localparam int OW = 13;
  localparam logic [63:0] BOOT_A = 64'h0000_0000_1C00_8080;
  localparam logic [63:0] BOOT_X = 64'h0000_0000_DEAD_BEEF;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [63:0] addr;
    logic [OW-1:0] exp;
    logic [63:0] exp_boot;
    string       name;
  } vec_t;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: default parameters
  logic        tm_a, valid_a, busy_a;
  logic [1:0]  op_a;
  logic [63:0] addr_a;
  logic        ready_a, pow_a, byp_a, clk_a, rstn_a, fetch_a, done_a, err_a, to_a;
  logic [63:0] boot_a;
  logic [3:0]  state_a;

  // dut_b: short drain timeout
  logic        tm_b, valid_b, busy_b;
  logic [1:0]  op_b;
  logic [63:0] addr_b;
  logic        ready_b, pow_b, byp_b, clk_b, rstn_b, fetch_b, done_b, err_b, to_b;
  logic [63:0] boot_b;
  logic [3:0]  state_b;

  cluster_power_seq dut_a (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tm_a),
    .cmd_valid_i(valid_a), .cmd_ready_o(ready_a), .cmd_op_i(op_a),
    .cmd_boot_addr_i(addr_a), .cluster_busy_i(busy_a),
    .cluster_pow_o(pow_a), .cluster_byp_o(byp_a), .cluster_clk_en_o(clk_a),
    .cluster_rstn_o(rstn_a), .cluster_fetch_enable_o(fetch_a),
    .cluster_boot_addr_o(boot_a), .state_o(state_a),
    .done_evt_o(done_a), .err_evt_o(err_a), .timeout_evt_o(to_a)
  );

  cluster_power_seq #(.DRAIN_TIMEOUT(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tm_b),
    .cmd_valid_i(valid_b), .cmd_ready_o(ready_b), .cmd_op_i(op_b),
    .cmd_boot_addr_i(addr_b), .cluster_busy_i(busy_b),
    .cluster_pow_o(pow_b), .cluster_byp_o(byp_b), .cluster_clk_en_o(clk_b),
    .cluster_rstn_o(rstn_b), .cluster_fetch_enable_o(fetch_b),
    .cluster_boot_addr_o(boot_b), .state_o(state_b),
    .done_evt_o(done_b), .err_evt_o(err_b), .timeout_evt_o(to_b)
  );

  logic [OW-1:0] act_a, act_b;
  assign act_a = {state_a, ready_a, pow_a, byp_a, clk_a, rstn_a, fetch_a, done_a, err_a, to_a};
  assign act_b = {state_b, ready_b, pow_b, byp_b, clk_b, rstn_b, fetch_b, done_b, err_b, to_b};

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [OW-1:0] mk(input state_e s, input logic rdy, input logic pow,
                                       input logic cen, input logic rstn, input logic fetch,
                                       input logic done, input logic err, input logic to);
    return {s, rdy, pow, ~cen, cen, rstn, fetch, done, err, to};
  endfunction

  // expected outputs k edges after the POWER_ON edge
  function automatic logic [OW-1:0] up_exp(input int k);
    if (k < 16)      return mk(PWR_UP,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    else if (k < 20) return mk(CLK_ON,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    else if (k < 28) return mk(RST_REL, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    else             return mk(READY,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, k == 28, 1'b0, 1'b0);
  endfunction

  // expected outputs j edges after the POWER_OFF edge; DRAIN is left on edge x
  function automatic logic [OW-1:0] down_exp(input int j, input int x, input logic tmo);
    if (j < x)           return mk(DRAIN,      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    else if (j < x + 8)  return mk(RST_ASSERT, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                   tmo && (j == x));
    else if (j < x + 12) return mk(CLK_OFF,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    else                 return mk(OFF,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, j == x + 12,
                                   1'b0, 1'b0);
  endfunction

  task automatic compare(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state,rdy,pow,byp,clken,rstn,fetch,done,err,to)",
               name, act, exp);
    end
  endtask

  task automatic check_addr(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: boot_addr got %h expected %h", name, act, exp);
    end
  endtask

  // push expectation, advance one edge, pop and compare
  task automatic step(input string name, input logic [OW-1:0] exp, input bit on_b);
    logic [OW-1:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #2;
    e = exp_q.pop_front();
    compare(name, on_b ? act_b : act_a, e);
  endtask

  // check without advancing the clock (asynchronous behaviour)
  task automatic check_now(input string name, input logic [OW-1:0] exp, input bit on_b);
    logic [OW-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    compare(name, on_b ? act_b : act_a, e);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];
  logic [OW-1:0] rst_vec;
  logic [OW-1:0] run_vec;

  initial begin
    rst_vec = mk(OFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec = mk(RUNNING, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{1'b1, OP_START,     64'h0, rst_vec | OW'(2), 64'h0,  "off_start"};
    vecs[1] = '{1'b1, OP_POWER_OFF, 64'h0, rst_vec | OW'(2), 64'h0,  "off_poweroff"};
    vecs[2] = '{1'b1, OP_NOP,       64'h0, rst_vec,          64'h0,  "off_nop"};
    vecs[3] = '{1'b0, OP_START,     64'h0, rst_vec,          64'h0,  "off_idle"};
    vecs[4] = '{1'b1, OP_START,     BOOT_X, run_vec | OW'(2), BOOT_A, "run_start"};
    vecs[5] = '{1'b1, OP_POWER_ON,  BOOT_X, run_vec | OW'(2), BOOT_A, "run_poweron"};
    vecs[6] = '{1'b1, OP_NOP,       BOOT_X, run_vec,          BOOT_A, "run_nop"};
    vecs[7] = '{1'b0, OP_POWER_OFF, BOOT_X, run_vec,          BOOT_A, "run_idle"};

    rst_n = 1'b0;
    tm_a = 1'b0; valid_a = 1'b0; busy_a = 1'b0; op_a = OP_NOP; addr_a = '0;
    tm_b = 1'b0; valid_b = 1'b0; busy_b = 1'b0; op_b = OP_NOP; addr_b = '0;
    repeat (2) @(posedge clk);
    #2;
    check_now("reset_a", rst_vec, 1'b0);
    check_now("reset_b", rst_vec, 1'b1);
    check_addr("reset_boot", boot_a, 64'h0);
    rst_n = 1'b1;

    // illegal / idle commands in OFF
    for (int i = 0; i < 4; i++) begin
      valid_a = vecs[i].valid; op_a = vecs[i].op; addr_a = vecs[i].addr;
      step(vecs[i].name, vecs[i].exp, 1'b0);
      check_addr(vecs[i].name, boot_a, vecs[i].exp_boot);
    end

    // power-up with START held from the cycle after POWER_ON: only taken once READY
    for (int k = 0; k < 30; k++) begin
      valid_a = 1'b1;
      op_a    = (k == 0) ? OP_POWER_ON : OP_START;
      addr_a  = BOOT_A;
      step("power_up", (k < 29) ? up_exp(k) : run_vec, 1'b0);
      if (k == 28) check_addr("boot_before_start", boot_a, 64'h0);
    end
    valid_a = 1'b0;
    check_addr("boot_latched", boot_a, BOOT_A);

    // commands in RUNNING
    for (int i = 4; i < 8; i++) begin
      valid_a = vecs[i].valid; op_a = vecs[i].op; addr_a = vecs[i].addr;
      step(vecs[i].name, vecs[i].exp, 1'b0);
      check_addr(vecs[i].name, boot_a, vecs[i].exp_boot);
    end

    // POWER_OFF with the cluster busy for 50 cycles
    for (int j = 0; j < 64; j++) begin
      valid_a = (j == 0);
      op_a    = OP_POWER_OFF;
      busy_a  = (j < 50);
      step("drain_busy", down_exp(j, 50, 1'b0), 1'b0);
    end
    busy_a = 1'b0; valid_a = 1'b0;

    // drain timeout on the short-timeout instance, POWER_OFF from READY
    for (int k = 0; k < 29; k++) begin
      valid_b = (k == 0);
      op_b    = OP_POWER_ON;
      step("b_power_up", up_exp(k), 1'b1);
    end
    valid_b = 1'b1; op_b = OP_POWER_ON;
    step("ready_poweron", mk(READY, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    for (int j = 0; j < 46; j++) begin
      valid_b = (j == 0);
      op_b    = OP_POWER_OFF;
      busy_b  = 1'b1;
      step("drain_timeout", down_exp(j, 32, 1'b1), 1'b1);
    end
    busy_b = 1'b0; valid_b = 1'b0;

    // asynchronous reset in the middle of PWR_UP, then test-mode reset bypass
    for (int k = 0; k < 6; k++) begin
      valid_a = (k == 0);
      op_a    = OP_POWER_ON;
      step("pre_reset", up_exp(k), 1'b0);
    end
    valid_a = 1'b0;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", rst_vec, 1'b0);
    check_addr("async_reset_boot", boot_a, 64'h0);
    tm_a = 1'b1;
    #1;
    check_now("tm_rst_low", rst_vec, 1'b0);
    rst_n = 1'b1;
    #1;
    check_now("tm_rst_high", mk(OFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    tm_a = 1'b0;
    #1;
    check_now("tm_off", rst_vec, 1'b0);
    step("idle_after_reset", rst_vec, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
